// File: rtl/fog_rate_decimator.sv
// fog_rate_decimator
//   Block-averages the FOG closed-loop step word and the demodulated error
//   over N = 2^k rate-sync samples and queues the averages in a small
//   first-word-fall-through FIFO that the CPU drains over valid/ready.
//   A block that finds the FIFO full is dropped and flagged in o_ovf.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_sample_sync      one-cycle pulse per loop rate period
//   i_step, i_err      signed samples, taken when i_sample_sync=1
//   i_dec_sel          decimation exponent k = min(i_dec_sel[3:0], MAX_K)
//   i_clr              synchronous clear, outranks everything in its cycle
//   i_ready            consumer accepts the FIFO head
//   o_valid            FIFO not empty, head on o_rate / o_err_avg
//   o_rate, o_err_avg  block averages at the FIFO head (held when empty)
//   o_level            FIFO occupancy
//   o_ovf              sticky: a block was dropped
module fog_rate_decimator #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 48,
  parameter int MAX_K      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_sample_sync,
  input  logic signed [DATA_W-1:0]    i_step,
  input  logic signed [DATA_W-1:0]    i_err,
  input  logic [31:0]                 i_dec_sel,
  input  logic                        i_clr,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic signed [DATA_W-1:0]    o_rate,
  output logic signed [DATA_W-1:0]    o_err_avg,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_ovf
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (MAX_K > 0) ? MAX_K : 1;

  // Counter value of the last sample of a 2^k block.
  function automatic logic [CNT_W-1:0] blk_last_cnt(input logic [3:0] k);
    logic [CNT_W:0] one_k;
    one_k = (CNT_W+1)'(1) << k;
    return CNT_W'(one_k - (CNT_W+1)'(1));
  endfunction

  // Floor division by 2^k; the result always fits DATA_W, so truncation is exact.
  function automatic logic signed [DATA_W-1:0] avg_trunc(input logic signed [ACC_W-1:0] sum,
                                                         input logic [3:0] k);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> k;
    return shifted[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0]  acc_step_p0, acc_err_p0;
  logic signed [ACC_W-1:0]  step_ext, err_ext, sum_step, sum_err;
  logic [CNT_W-1:0]         cnt_p0;
  logic [3:0]               k_lat_p0, k_sel, k_eff;
  logic                     block_last;
  logic signed [DATA_W-1:0] res_step_p1, res_err_p1;
  logic                     vld_p1;
  logic                     unused_dec_sel;

  assign unused_dec_sel = ^i_dec_sel[31:4];

  assign k_sel      = (i_dec_sel[3:0] > 4'(MAX_K)) ? 4'(MAX_K) : i_dec_sel[3:0];
  // A new k only takes effect at the first sample of a block.
  assign k_eff      = (cnt_p0 == '0) ? k_sel : k_lat_p0;
  assign step_ext   = {{(ACC_W-DATA_W){i_step[DATA_W-1]}}, i_step};
  assign err_ext    = {{(ACC_W-DATA_W){i_err[DATA_W-1]}}, i_err};
  assign sum_step   = acc_step_p0 + step_ext;
  assign sum_err    = acc_err_p0 + err_ext;
  assign block_last = i_sample_sync && (cnt_p0 == blk_last_cnt(k_eff));

  // ---- stage p0: accumulate samples, detect block end ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_step_p0 <= '0;
      acc_err_p0  <= '0;
      cnt_p0      <= '0;
      k_lat_p0    <= '0;
      vld_p1      <= 1'b0;
    end else if (i_clr) begin
      acc_step_p0 <= '0;
      acc_err_p0  <= '0;
      cnt_p0      <= '0;
      k_lat_p0    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= block_last;
      if (i_sample_sync) begin
        if (cnt_p0 == '0) k_lat_p0 <= k_sel;
        if (block_last) begin
          acc_step_p0 <= '0;
          acc_err_p0  <= '0;
          cnt_p0      <= '0;
        end else begin
          acc_step_p0 <= sum_step;
          acc_err_p0  <= sum_err;
          cnt_p0      <= cnt_p0 + CNT_W'(1);
        end
      end
    end
  end

  // ---- stage p1: block averages waiting to be pushed ----
  always_ff @(posedge i_clk) begin
    if (block_last) begin
      res_step_p1 <= avg_trunc(sum_step, k_eff);
      res_err_p1  <= avg_trunc(sum_err, k_eff);
    end
  end

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0]    lvl_after_pop;
  logic                pop, full, push_ok;

  assign o_valid       = (o_level != '0);
  assign pop           = o_valid & i_ready;
  assign full          = (o_level == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok       = vld_p1 & (~full | pop);
  assign rd_next       = rd_ptr + PTR_W'(pop);
  assign lvl_after_pop = o_level - LVL_W'(pop);

  // ---- stage p2: FIFO storage and registered head ----
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= {res_step_p1, res_err_p1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_level   <= '0;
      o_ovf     <= 1'b0;
      o_rate    <= '0;
      o_err_avg <= '0;
    end else if (i_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_level   <= '0;
      o_ovf     <= 1'b0;
      o_rate    <= '0;
      o_err_avg <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_next;
      o_level <= o_level + LVL_W'(push_ok) - LVL_W'(pop);
      if (vld_p1 && !push_ok) o_ovf <= 1'b1;
      // Head comes from storage if entries remain after the pop, otherwise
      // the incoming push becomes the head directly; with neither, it holds.
      if (lvl_after_pop != '0) begin
        {o_rate, o_err_avg} <= mem[rd_next];
      end else if (push_ok) begin
        o_rate    <= res_step_p1;
        o_err_avg <= res_err_p1;
      end
    end
  end

endmodule

// File: tb/tb_fog_rate_decimator.sv
module tb_fog_rate_decimator;

  localparam int DEPTH = 4;
  localparam int MAXK  = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sync = 1'b0;
  logic signed [31:0] step = '0;
  logic signed [31:0] err = '0;
  logic [31:0]        dec_sel = '0;
  logic               clr = 1'b0;
  logic               ready = 1'b0;
  logic               o_valid;
  logic signed [31:0] o_rate, o_err_avg;
  logic [2:0]         o_level;
  logic               o_ovf;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  fog_rate_decimator #(.DATA_W(32), .ACC_W(48), .MAX_K(MAXK), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_sync(sync), .i_step(step), .i_err(err),
    .i_dec_sel(dec_sel), .i_clr(clr), .i_ready(ready), .o_valid(o_valid),
    .o_rate(o_rate), .o_err_avg(o_err_avg), .o_level(o_level), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a list of samples per block and a queue of results.
  logic signed [31:0] qs[$], qe[$];
  longint             bs, be;
  int                 bn, bk;
  bit                 m_pend, m_ovf;
  logic signed [31:0] pv_s, pv_e, m_hs, m_he;

  task automatic model_clear();
    qs.delete(); qe.delete();
    bs = 0; be = 0; bn = 0; bk = 0;
    m_pend = 0; m_ovf = 0; m_hs = 0; m_he = 0; pv_s = 0; pv_e = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (rst || clr) begin
        model_clear();
      end else begin
        if (qs.size() > 0 && ready) begin
          void'(qs.pop_front());
          void'(qe.pop_front());
        end
        if (m_pend) begin
          if (qs.size() < DEPTH) begin
            qs.push_back(pv_s);
            qe.push_back(pv_e);
          end else begin
            m_ovf = 1;
          end
        end
        if (qs.size() > 0) begin
          m_hs = qs[0];
          m_he = qe[0];
        end
        m_pend = 0;
        if (sync) begin
          if (bn == 0) bk = (int'(dec_sel[3:0]) > MAXK) ? MAXK : int'(dec_sel[3:0]);
          bs += longint'(step);
          be += longint'(err);
          bn++;
          if (bn == (1 << bk)) begin
            m_pend = 1;
            pv_s = 32'(bs >>> bk);
            pv_e = 32'(be >>> bk);
            bs = 0; be = 0; bn = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid", longint'(o_valid), longint'(qs.size() > 0));
        chk("level", longint'(o_level), longint'(qs.size()));
        chk("ovf", longint'(o_ovf), longint'(m_ovf));
        chk("rate", longint'(o_rate), longint'(m_hs));
        chk("err_avg", longint'(o_err_avg), longint'(m_he));
      end
    end
  end

  task automatic drv(input bit s, input logic signed [31:0] st, input logic signed [31:0] er,
                     input bit rdy, input bit c);
    @(posedge clk);
    #1;
    sync = s; step = st; err = er; ready = rdy; clr = c;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drv(1'b0, 0, 0, rdy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic signed [31:0] s_max, s_min;

  initial begin
    s_max = 32'sh7FFFFFFF;
    s_min = 32'sh80000000;
    dec_sel = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_level", longint'(o_level), 0);
    chk("rst_ovf", longint'(o_ovf), 0);
    chk("rst_rate", longint'(o_rate), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // k=2 basic block
    drv(1, 10, -4, 0, 0);
    drv(1, 20, -4, 0, 0);
    drv(1, 30, -4, 0, 0);
    drv(1, 41, -8, 0, 0);
    idle(1, 0);
    @(negedge clk);
    chk("lat_valid_t1", longint'(o_valid), 0);
    idle(1, 0);
    @(negedge clk);
    chk("lat_valid_t2", longint'(o_valid), 1);
    chk("k2_rate", longint'(o_rate), 25);
    chk("k2_err", longint'(o_err_avg), -5);
    chk("k2_level", longint'(o_level), 1);
    drv(0, 0, 0, 1, 0);
    idle(1, 0);
    @(negedge clk);
    chk("pop_level", longint'(o_level), 0);
    chk("hold_rate", longint'(o_rate), 25);

    // k=0 overflow
    dec_sel = 32'd0;
    for (int i = 1; i <= 6; i++) drv(1, i, -i, 0, 0);
    idle(2, 0);
    @(negedge clk);
    chk("full_level", longint'(o_level), 4);
    chk("full_ovf", longint'(o_ovf), 1);
    chk("full_head", longint'(o_rate), 1);
    idle(5, 1);
    idle(1, 0);
    @(negedge clk);
    chk("drain_valid", longint'(o_valid), 0);
    chk("drain_hold", longint'(o_rate), 4);
    drv(0, 0, 0, 0, 1);
    idle(1, 0);
    @(negedge clk);
    chk("clr_ovf", longint'(o_ovf), 0);

    // full FIFO with simultaneous push and pop
    for (int v = 11; v <= 14; v++) drv(1, v, v, 0, 0);
    idle(2, 0);
    @(negedge clk);
    chk("fill_level", longint'(o_level), 4);
    drv(1, 15, 15, 0, 0);
    drv(0, 0, 0, 1, 0);
    idle(1, 0);
    @(negedge clk);
    chk("pp_level", longint'(o_level), 4);
    chk("pp_ovf", longint'(o_ovf), 0);
    chk("pp_head", longint'(o_rate), 12);
    idle(6, 1);

    // floor rounding and extremes
    dec_sel = 32'd1;
    drv(1, -3, 5, 1, 0);
    drv(1, -4, 6, 1, 0);
    idle(2, 1);
    @(negedge clk);
    chk("floor_rate", longint'(o_rate), -4);
    chk("floor_err", longint'(o_err_avg), 5);
    dec_sel = 32'd2;
    repeat (4) drv(1, s_max, s_min, 1, 0);
    idle(2, 1);
    @(negedge clk);
    chk("max_rate", longint'(o_rate), longint'(s_max));
    chk("min_err", longint'(o_err_avg), longint'(s_min));

    // k change mid-block
    dec_sel = 32'd2;
    drv(1, 4, 0, 1, 0);
    drv(1, 8, 0, 1, 0);
    dec_sel = 32'd0;
    drv(1, 12, 0, 1, 0);
    drv(1, 16, 0, 1, 0);
    drv(1, 100, 0, 1, 0);
    drv(1, 200, 0, 1, 0);
    @(negedge clk);
    chk("ksw_block", longint'(o_rate), 10);
    idle(1, 1);
    @(negedge clk);
    chk("ksw_single1", longint'(o_rate), 100);
    idle(1, 1);
    @(negedge clk);
    chk("ksw_single2", longint'(o_rate), 200);
    idle(2, 0);

    // clear mid-block with a full, overflowed FIFO
    for (int i = 7; i <= 12; i++) drv(1, i, i, 0, 0);
    idle(2, 0);
    @(negedge clk);
    chk("pre_clr_ovf", longint'(o_ovf), 1);
    dec_sel = 32'd2;
    drv(1, 1, 1, 0, 0);
    drv(1, 2, 2, 0, 0);
    drv(1, 3, 3, 0, 1);
    idle(1, 0);
    @(negedge clk);
    chk("clr_level", longint'(o_level), 0);
    chk("clr_valid", longint'(o_valid), 0);
    chk("clr_ovf2", longint'(o_ovf), 0);
    chk("clr_rate", longint'(o_rate), 0);
    drv(1, 20, 0, 0, 0);
    drv(1, 20, 0, 0, 0);
    drv(1, 20, 0, 0, 0);
    drv(1, 24, -4, 0, 0);
    idle(2, 0);
    @(negedge clk);
    chk("post_clr_rate", longint'(o_rate), 21);
    chk("post_clr_err", longint'(o_err_avg), -1);
    chk("post_clr_level", longint'(o_level), 1);
    idle(2, 1);

    // k clamped to MAX_K (1024-sample block)
    dec_sel = 32'hFFFF_FFFF;
    for (int i = 0; i < 1024; i++) drv(1, i * 3 - 1000, -i, 1, 0);
    idle(2, 1);
    @(negedge clk);
    chk("clamp_rate", longint'(o_rate), 534);
    chk("clamp_err", longint'(o_err_avg), -512);
    idle(3, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fog_rate_decimator.md
Name: fog_rate_decimator

Overview:
- Downstream consumer of the FOG loop outputs: closed-loop step (rate word) and demodulated error.
- Accumulates both signals on each rate-sync pulse over a block of N = 2^k samples.
- Produces block averages and buffers them in a small FIFO.
- The NIOS II reads the FIFO over a valid/ready handshake. Overflow is flagged, never silently merged.

Parameters:
- DATA_W, 32, width of i_step / i_err and of the averaged outputs (signed).
- ACC_W, 48, accumulator width (signed); must be at least DATA_W + MAX_K.
- MAX_K, 10, maximum decimation exponent; k is clamped to this value.
- FIFO_DEPTH, 4, number of result entries; power of two.

Ports:
- i_clk  in  1  system logic clock (CPU logic domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_sample_sync  in  1  one-cycle pulse, one per loop rate period (rate sync from the error generator).
- i_step  in  DATA_W  signed feedback step word; sampled when i_sample_sync=1.
- i_err  in  DATA_W  signed error word; sampled when i_sample_sync=1.
- i_dec_sel  in  32  decimation exponent k = min(i_dec_sel[3:0], MAX_K).
- i_clr  in  1  synchronous clear (one cycle).
- i_ready  in  1  consumer accepts the FIFO head this cycle.
- o_valid  out  1  FIFO is not empty; the head is on o_rate / o_err_avg.
- o_rate  out  DATA_W  signed block average of i_step (FIFO head).
- o_err_avg  out  DATA_W  signed block average of i_err (FIFO head).
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_ovf  out  1  sticky overflow flag: a block was dropped.

Behaviour:
- Reset (async, i_rst=1) clears:
  - acc_step, acc_err, sample counter, latched k, push pipeline, FIFO pointers;
  - o_valid=0, o_rate=0, o_err_avg=0, o_level=0, o_ovf=0.
- i_clr has the same effect synchronously and outranks every other event in its cycle; an i_sample_sync in that cycle is discarded.
- k latching: k is taken from i_dec_sel only when the sample counter is 0 and a sample arrives (block start). Changing i_dec_sel mid-block affects only the next block.
- Accumulate: on each i_sample_sync, acc_step += sign-extended i_step and acc_err += sign-extended i_err, both in ACC_W.
- Block end: on the sample where cnt == 2^k − 1:
  - res_step <= (acc_step + i_step) >>> k, arithmetic shift;
  - res_err is computed the same way;
  - both are truncated to DATA_W (always exact, since the sum of N values ≥ −2^(DATA_W−1) fits);
  - accumulators and counter return to 0 in the same cycle, and push_pend <= 1.
- k=0 passes each sample through unchanged.
- Push: in the cycle after block end, push_pend writes {res_step, res_err} into the FIFO.
  - Back-to-back final samples (k=0, pulse every cycle) must push every cycle without loss.
- Latency: final sample at cycle T → entry written at T+1 → o_valid=1 at T+2 if the FIFO was empty (registered, first-word-fall-through head).
- FIFO full:
  - a push with o_level == FIFO_DEPTH and no simultaneous pop drops the new entry and sets o_ovf=1;
  - o_ovf is cleared only by i_clr or reset.
- Simultaneous push and pop when full: the pop frees a slot, the push is accepted, o_level is unchanged and o_ovf is not set.
- Pop: occurs when o_valid & i_ready. The next head appears the following cycle. i_ready while empty is ignored (no underflow; o_level stays 0).
- Pointers wrap modulo FIFO_DEPTH. o_level is tracked by a separate counter, with push/pop balanced as above.
- o_rate / o_err_avg hold their last head value when the FIFO is empty (not forced to 0 after the first pop).

Test Plan:
- Reset, k=2, four pulses with i_step = 10, 20, 30, 41 and i_err = −4, −4, −4, −8 → after 2 cycles o_valid=1, o_rate=25 (101>>>2), o_err_avg=−5, o_level=1.
- k=0, i_sample_sync held high for 6 cycles with i_step=1..6, i_ready=0 → FIFO holds 1..4, o_level=4, o_ovf=1; then i_ready=1 → reads 1, 2, 3, 4, then o_valid=0.
- FIFO full and i_ready=1 in the same cycle as a push → o_level stays 4, o_ovf stays 0, the new value is appended in order.
- k=1, i_step = −3, −4 → o_rate = −4 (−7 >>> 1, floor). Extreme inputs i_step = 0x7FFFFFFF ×4 with k=2 → o_rate = 0x7FFFFFFF.
- i_dec_sel changed from 2 to 0 after the 2nd sample of a block → that block still averages 4 samples; following blocks are single-sample.
- i_clr asserted together with the 3rd of 4 samples and a non-empty FIFO → o_level=0, o_valid=0, o_ovf=0, and the next block starts from cnt=0 with acc=0.
